// File: rtl/trap_sequencer_if.sv
// Trap sequencer bus: exception report and CSR snapshot in, CSR write port and pipeline control out.
interface trap_sequencer_if;
  logic        excPresent_i;
  logic [31:0] excCause_i;
  logic [31:0] trapInfo_i;
  logic [31:0] pc_i;
  logic        mret_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic [31:0] mstatus_i;
  logic        csrWe_o;
  logic [11:0] csrAddr_o;
  logic [31:0] csrWdata_o;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] pcRedirect_o;
  logic        pcRedirectValid_o;
  logic        busy_o;

  modport slave (
    input  excPresent_i, excCause_i, trapInfo_i, pc_i, mret_i, mtvec_i, mepc_i, mstatus_i,
    output csrWe_o, csrAddr_o, csrWdata_o, stall_o, flush_o, pcRedirect_o, pcRedirectValid_o, busy_o
  );

  modport master (
    output excPresent_i, excCause_i, trapInfo_i, pc_i, mret_i, mtvec_i, mepc_i, mstatus_i,
    input  csrWe_o, csrAddr_o, csrWdata_o, stall_o, flush_o, pcRedirect_o, pcRedirectValid_o, busy_o
  );
endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer; trap: 4 CSR writes then redirect (N+1..N+5), MRET: write then redirect (N+1..N+2).
// No backpressure: the pipeline is stalled from the accept cycle through the jump, and events arriving while busy are dropped.
module trap_sequencer #(
  parameter bit VECTORED_EN = 1'b1
) (
  input logic             clk_i,
  input logic             rst_ni,
  trap_sequencer_if.slave io
);

  typedef enum logic [2:0] {
    IDLE, T_EPC, T_CAUSE, T_TVAL, T_STATUS, T_JUMP, R_STATUS, R_JUMP
  } state_t;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_tval;
  logic [31:0] r_tvec;
  logic [31:0] r_mepc;

  logic        w_take_trap;
  logic        w_take_mret;
  logic [31:0] w_ms_trap;
  logic [31:0] w_ms_mret;
  logic [31:0] w_tvec_base;
  logic [31:0] w_trap_target;

  logic        w_we;
  logic [11:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic        w_flush;
  logic [31:0] w_redirect;
  logic        w_redirect_vld;

  // Interrupts are masked by MIE; synchronous exceptions always win, including over MRET.
  assign w_take_trap = (r_state == IDLE) && io.excPresent_i &&
                       (!io.excCause_i[31] || io.mstatus_i[3]);
  assign w_take_mret = (r_state == IDLE) && io.mret_i && !w_take_trap;

  always_comb begin
    w_ms_trap    = io.mstatus_i;
    w_ms_trap[7] = io.mstatus_i[3];
    w_ms_trap[3] = 1'b0;
  end

  always_comb begin
    w_ms_mret    = io.mstatus_i;
    w_ms_mret[3] = io.mstatus_i[7];
    w_ms_mret[7] = 1'b1;
  end

  assign w_tvec_base   = r_tvec & 32'hFFFF_FFFC;
  assign w_trap_target = (VECTORED_EN && (r_tvec[1:0] == 2'b01) && r_cause[31])
                         ? w_tvec_base + {r_cause[29:0], 2'b00}
                         : w_tvec_base;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_cause <= '0;
      r_tval  <= '0;
      r_tvec  <= '0;
      r_mepc  <= '0;
    end else begin
      r_state <= w_next;
      if (w_take_trap) begin
        r_pc    <= io.pc_i;
        r_cause <= io.excCause_i;
        r_tval  <= io.trapInfo_i;
        r_tvec  <= io.mtvec_i;
      end else if (w_take_mret) begin
        r_mepc  <= io.mepc_i;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    w_we           = 1'b0;
    w_addr         = '0;
    w_wdata        = '0;
    w_stall        = 1'b0;
    w_flush        = 1'b0;
    w_redirect     = '0;
    w_redirect_vld = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_take_trap) begin
          w_next  = T_EPC;
          w_stall = 1'b1;
        end else if (w_take_mret) begin
          w_next  = R_STATUS;
          w_stall = 1'b1;
        end
      end
      T_EPC: begin
        w_we    = 1'b1;
        w_addr  = CSR_MEPC;
        w_wdata = r_pc & 32'hFFFF_FFFC;
        w_stall = 1'b1;
        w_next  = T_CAUSE;
      end
      T_CAUSE: begin
        w_we    = 1'b1;
        w_addr  = CSR_MCAUSE;
        w_wdata = r_cause;
        w_stall = 1'b1;
        w_next  = T_TVAL;
      end
      T_TVAL: begin
        w_we    = 1'b1;
        w_addr  = CSR_MTVAL;
        w_wdata = r_tval;
        w_stall = 1'b1;
        w_next  = T_STATUS;
      end
      T_STATUS: begin
        w_we    = 1'b1;
        w_addr  = CSR_MSTATUS;
        w_wdata = w_ms_trap;
        w_stall = 1'b1;
        w_next  = T_JUMP;
      end
      T_JUMP: begin
        w_redirect     = w_trap_target;
        w_redirect_vld = 1'b1;
        w_flush        = 1'b1;
        w_stall        = 1'b1;
        w_next         = IDLE;
      end
      R_STATUS: begin
        w_we    = 1'b1;
        w_addr  = CSR_MSTATUS;
        w_wdata = w_ms_mret;
        w_stall = 1'b1;
        w_next  = R_JUMP;
      end
      R_JUMP: begin
        w_redirect     = r_mepc & 32'hFFFF_FFFC;
        w_redirect_vld = 1'b1;
        w_flush        = 1'b1;
        w_stall        = 1'b1;
        w_next         = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign io.csrWe_o           = w_we;
  assign io.csrAddr_o         = w_addr;
  assign io.csrWdata_o        = w_wdata;
  assign io.stall_o           = w_stall;
  assign io.flush_o           = w_flush;
  assign io.pcRedirect_o      = w_redirect;
  assign io.pcRedirectValid_o = w_redirect_vld;
  assign io.busy_o            = (r_state != IDLE);

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed cases, randomized traffic, and a mid-sequence reset.
module tb_trap_sequencer;

  logic clk_i = 1'b0;
  logic rst_ni;

  trap_sequencer_if bus ();

  trap_sequencer #(.VECTORED_EN(1'b1)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .io     (bus)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    bit          exc;
    logic [31:0] cause;
    logic [31:0] tval;
    logic [31:0] pc;
    bit          mret;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic [31:0] ms;
  } stim_t;

  typedef struct {
    int          cyc;
    bit          jump;
    logic [11:0] addr;
    logic [31:0] data;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  bit    exp_stall[int];
  bit    exp_busy[int];
  int    total = 0;
  int    bad = 0;
  bit    mon_en = 1'b0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, want);
    end
  endfunction

  function automatic logic [31:0] trap_ms(logic [31:0] m);
    return (m & ~32'h88) | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_ms(logic [31:0] m);
    return (m & ~32'h88) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  function automatic logic [31:0] trap_target(logic [31:0] mtvec, logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (mtvec[1:0] == 2'd1 && cause[31])
      return base + 32'd4 * (cause & 32'h7FFF_FFFF);
    return base;
  endfunction

  task automatic add(bit exc, logic [31:0] cause, logic [31:0] tval, logic [31:0] pc,
                     bit mret, logic [31:0] mtvec, logic [31:0] mepc, logic [31:0] ms);
    stim_t s;
    s.exc = exc; s.cause = cause; s.tval = tval; s.pc = pc;
    s.mret = mret; s.mtvec = mtvec; s.mepc = mepc; s.ms = ms;
    stim_q.push_back(s);
  endtask

  task automatic add_idle(int n, logic [31:0] ms);
    for (int k = 0; k < n; k++)
      add(1'b0, $urandom, $urandom, $urandom, 1'b0, $urandom, $urandom, ms);
  endtask

  task automatic push_exp(int c, bit j, logic [11:0] a, logic [31:0] d);
    exp_t e;
    e.cyc = c; e.jump = j; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  // Must be entered just after a rising edge with the DUT idle.
  task automatic run_seq();
    int    base;
    int    free;
    int    c;
    stim_t s;
    add_idle(8, 32'h0);
    base = cyc + 1;
    free = base;
    for (int i = 0; i < stim_q.size(); i++) begin
      c = base + i;
      s = stim_q[i];
      if (c >= free) begin
        if (s.exc && (!s.cause[31] || s.ms[3])) begin
          for (int k = 0; k <= 5; k++) exp_stall[c + k] = 1'b1;
          for (int k = 1; k <= 5; k++) exp_busy[c + k] = 1'b1;
          push_exp(c + 1, 1'b0, 12'h341, s.pc & 32'hFFFF_FFFC);
          push_exp(c + 2, 1'b0, 12'h342, s.cause);
          push_exp(c + 3, 1'b0, 12'h343, s.tval);
          push_exp(c + 4, 1'b0, 12'h300, trap_ms(stim_q[i + 4].ms));
          push_exp(c + 5, 1'b1, 12'h000, trap_target(s.mtvec, s.cause));
          free = c + 6;
        end else if (s.mret) begin
          for (int k = 0; k <= 2; k++) exp_stall[c + k] = 1'b1;
          for (int k = 1; k <= 2; k++) exp_busy[c + k] = 1'b1;
          push_exp(c + 1, 1'b0, 12'h300, mret_ms(stim_q[i + 1].ms));
          push_exp(c + 2, 1'b1, 12'h000, s.mepc & 32'hFFFF_FFFC);
          free = c + 3;
        end
      end
    end
    for (int i = 0; i < stim_q.size(); i++) begin
      @(posedge clk_i);
      #1;
      s = stim_q[i];
      bus.excPresent_i = s.exc;
      bus.excCause_i   = s.cause;
      bus.trapInfo_i   = s.tval;
      bus.pc_i         = s.pc;
      bus.mret_i       = s.mret;
      bus.mtvec_i      = s.mtvec;
      bus.mepc_i       = s.mepc;
      bus.mstatus_i    = s.ms;
    end
    stim_q.delete();
    @(posedge clk_i);
    #1;
    chk("exp_drained", exp_q.size(), 0);
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      chk("stall", {31'b0, bus.stall_o}, exp_stall.exists(cyc));
      chk("busy", {31'b0, bus.busy_o}, exp_busy.exists(cyc));
      if (bus.csrWe_o || bus.pcRedirectValid_o) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_strobe cyc=%0d we=%b addr=%h redirect_vld=%b",
                   cyc, bus.csrWe_o, bus.csrAddr_o, bus.pcRedirectValid_o);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ev_cycle", cyc, e.cyc);
          chk("ev_is_jump", {31'b0, bus.pcRedirectValid_o}, {31'b0, e.jump});
          if (e.jump) begin
            chk("redirect", bus.pcRedirect_o, e.data);
            chk("jump_flush", {31'b0, bus.flush_o}, 32'd1);
            chk("jump_we", {31'b0, bus.csrWe_o}, 32'd0);
          end else begin
            chk("csr_addr", {20'b0, bus.csrAddr_o}, {20'b0, e.addr});
            chk("csr_wdata", bus.csrWdata_o, e.data);
            chk("write_flush", {31'b0, bus.flush_o}, 32'd0);
          end
        end
      end else begin
        chk("idle_addr", {20'b0, bus.csrAddr_o}, 32'd0);
        chk("idle_wdata", bus.csrWdata_o, 32'd0);
        chk("idle_redirect", bus.pcRedirect_o, 32'd0);
        chk("idle_flush", {31'b0, bus.flush_o}, 32'd0);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_event cyc=%0d want_cyc=%0d addr=%h data=%h",
                 cyc, exp_q[0].cyc, exp_q[0].addr, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_we"}, {31'b0, bus.csrWe_o}, 32'd0);
    chk({tag, "_addr"}, {20'b0, bus.csrAddr_o}, 32'd0);
    chk({tag, "_wdata"}, bus.csrWdata_o, 32'd0);
    chk({tag, "_stall"}, {31'b0, bus.stall_o}, 32'd0);
    chk({tag, "_flush"}, {31'b0, bus.flush_o}, 32'd0);
    chk({tag, "_redirect"}, bus.pcRedirect_o, 32'd0);
    chk({tag, "_redirect_vld"}, {31'b0, bus.pcRedirectValid_o}, 32'd0);
    chk({tag, "_busy"}, {31'b0, bus.busy_o}, 32'd0);
  endtask

  task automatic drive_idle();
    bus.excPresent_i = 1'b0;
    bus.excCause_i   = '0;
    bus.trapInfo_i   = '0;
    bus.pc_i         = '0;
    bus.mret_i       = 1'b0;
    bus.mtvec_i      = '0;
    bus.mepc_i       = '0;
    bus.mstatus_i    = '0;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] tv;
    int          r;

    rst_ni = 1'b0;
    drive_idle();
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;

    // Directed cases from the block's behaviour list.
    add(1'b1, 32'd4, 32'h203, 32'h100, 1'b0, 32'h80, 32'h0, 32'h8);
    add_idle(6, 32'h8);
    add(1'b1, 32'h8000_0007, 32'h0, 32'h300, 1'b0, 32'h81, 32'h0, 32'h8);
    add_idle(6, 32'h8);
    add(1'b1, 32'h8000_0007, 32'h0, 32'h300, 1'b0, 32'h81, 32'h0, 32'h0);
    add_idle(2, 32'h0);
    add(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h204, 32'h80);
    add_idle(3, 32'h80);
    add(1'b1, 32'd2, 32'h11, 32'h404, 1'b1, 32'h200, 32'h888, 32'h8);
    add_idle(1, 32'h8);
    add(1'b1, 32'd5, 32'h22, 32'h500, 1'b0, 32'h300, 32'h0, 32'h8);
    add_idle(6, 32'h8);
    add(1'b1, 32'h8000_0003, 32'h0, 32'h600, 1'b0, 32'hFFFF_FFFD, 32'h0, 32'h8);
    add_idle(6, 32'h8);
    add(1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h207, 32'hFFFF_FF7F);
    add_idle(3, 32'hFFFF_FF7F);
    run_seq();

    // Randomized traffic, including events that land while busy.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 9);
      v  = $urandom;
      tv = $urandom;
      tv[1] = 1'b0;
      if (v[0]) v = v | 32'h8000_0000;
      else      v = v & 32'h1F;
      add(r < 3, v, $urandom, $urandom, (r >= 2) && (r < 5), tv, $urandom, $urandom);
    end
    run_seq();

    // Reset in the middle of a trap sequence, then a clean trap.
    mon_en = 1'b0;
    bus.excPresent_i = 1'b1;
    bus.excCause_i   = 32'd2;
    bus.trapInfo_i   = 32'h55;
    bus.pc_i         = 32'h40;
    bus.mtvec_i      = 32'h100;
    bus.mstatus_i    = 32'h0;
    @(posedge clk_i);
    #1;
    bus.excPresent_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("tval_state_we", {31'b0, bus.csrWe_o}, 32'd1);
    chk("tval_state_addr", {20'b0, bus.csrAddr_o}, 32'h343);
    rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    mon_en = 1'b1;
    add(1'b1, 32'd7, 32'h77, 32'h123, 1'b0, 32'h400, 32'h0, 32'h88);
    add_idle(6, 32'h88);
    run_seq();
    mon_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
